// File: rtl/shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR by a variable amount, at most STEP bits per clock,
// with a start/busy/done handshake so the ALU control can stall on long shifts.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int AW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    localparam logic [AW:0] STEP_C  = (AW+1)'(STEP);
    localparam logic [AW:0] WIDTH_C = (AW+1)'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AW:0]      rem_q, rem_d;
    logic [1:0]       op_q, op_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             busy_q, done_q;

    logic [AW:0]      step_amt;
    logic [AW:0]      rot_amt;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shifted;

    // One step of the datapath: shift the work register by min(remaining, STEP).
    always_comb begin
        step_amt  = (rem_q > STEP_C) ? STEP_C : rem_q;
        rot_amt   = WIDTH_C - step_amt;
        fill_mask = ~({WIDTH{1'b1}} >> step_amt);
        case (op_q)
            OP_SLL:  shifted = work_q << step_amt;
            OP_SRL:  shifted = work_q >> step_amt;
            OP_SRA:  shifted = (work_q >> step_amt) | (sign_q ? fill_mask : '0);
            default: shifted = (work_q >> step_amt) | (work_q << rot_amt);
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d = din;
                    op_d   = op;
                    sign_d = din[WIDTH-1];
                    rem_d  = {1'b0, amt};
                    if (amt == '0) begin
                        state_d = S_DONE;
                        dout_d  = din;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step_amt;
                if (rem_q == step_amt) begin
                    state_d = S_DONE;
                    dout_d  = shifted;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // busy/done are registered from the next state so outputs never depend on inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            dout_q  <= dout_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: three instances (STEP 1, 4, 32) share one stimulus stream and are
// checked every cycle against a transaction-level timing/result model, plus literal checks.
module tb_shift_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [4:0]  amt = 5'd0;
    logic [31:0] din = 32'd0;

    logic        busy_w [3];
    logic        done_w [3];
    logic [31:0] dout_w [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic int step_of(int i);
        return (i == 0) ? 1 : (i == 1) ? 4 : 32;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        shift_unit #(
            .WIDTH(32),
            .STEP((gi == 0) ? 1 : (gi == 1) ? 4 : 32)
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .start(start),
            .op   (op),
            .amt  (amt),
            .din  (din),
            .busy (busy_w[gi]),
            .done (done_w[gi]),
            .dout (dout_w[gi])
        );
    end

    // Reference result: the single-step equivalent of each operation.
    function automatic logic [31:0] ref_fn(logic [1:0] o, logic [31:0] d, int a);
        logic [63:0] dd;
        logic [31:0] r;
        dd = {d, d};
        case (o)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = 32'($signed(d) >>> a);
            default: begin
                dd = dd >> a;
                r  = dd[31:0];
            end
        endcase
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted op stays busy for ceil(amt/STEP)+1 cycles,
    // done is asserted in the last of them and dout takes the reference result then.
    logic        m_busy [3] = '{default: 1'b0};
    logic        m_done [3] = '{default: 1'b0};
    logic [31:0] m_dout [3] = '{default: 32'd0};
    logic [31:0] m_res  [3] = '{default: 32'd0};
    int          m_cnt  [3] = '{default: 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_dout[i] <= 32'd0;
                m_cnt[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!m_busy[i]) begin
                    if (start) begin
                        m_busy[i] <= 1'b1;
                        m_res[i]  <= ref_fn(op, din, int'(amt));
                        if (amt == 5'd0) begin
                            m_done[i] <= 1'b1;
                            m_dout[i] <= din;
                            m_cnt[i]  <= 0;
                        end else begin
                            m_cnt[i] <= (int'(amt) + step_of(i) - 1) / step_of(i);
                        end
                    end
                end else if (m_done[i]) begin
                    m_done[i] <= 1'b0;
                    m_busy[i] <= 1'b0;
                end else if (m_cnt[i] == 1) begin
                    m_done[i] <= 1'b1;
                    m_dout[i] <= m_res[i];
                    m_cnt[i]  <= 0;
                end else begin
                    m_cnt[i] <= m_cnt[i] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s%0d_busy", step_of(i)), {31'd0, busy_w[i]}, {31'd0, m_busy[i]});
            chk($sformatf("s%0d_done", step_of(i)), {31'd0, done_w[i]}, {31'd0, m_done[i]});
            chk($sformatf("s%0d_dout", step_of(i)), dout_w[i], m_dout[i]);
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy_w[0] || busy_w[1] || busy_w[2]) && k < 80) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (busy_w[0] || busy_w[1] || busy_w[2]) begin
            fails++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", k);
        end
    endtask

    // One operation; lat/bcnt measured on the STEP=4 instance in cycles after acceptance.
    task automatic do_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] a,
                         output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        din   = d;
        amt   = a;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        for (int k = 1; k <= 80; k++) begin
            if (busy_w[1]) bcnt++;
            if (done_w[1] && lat == 0) lat = k;
            if (!busy_w[0] && !busy_w[1] && !busy_w[2]) break;
            @(negedge clk);
        end
        wait_idle();
        $display("[TB] op=%0d din=%h amt=%0d -> dout4=%h lat4=%0d busy4=%0d",
                 o, d, a, dout_w[1], lat, bcnt);
    endtask

    initial begin
        int lat, bcnt, dmask, dcnt;

        // model pins
        chk("model_sll", ref_fn(2'b00, 32'h0000_0001, 31), 32'h8000_0000);
        chk("model_sra", ref_fn(2'b10, 32'hF000_0000, 4), 32'hFF00_0000);
        chk("model_ror", ref_fn(2'b11, 32'h1234_5678, 8), 32'h7812_3456);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy_w[1]}, 32'd0);
        chk("rst_done", {31'd0, done_w[1]}, 32'd0);
        chk("rst_dout", dout_w[1], 32'd0);
        rst = 1'b0;

        do_op(2'b00, 32'h0000_0001, 5'd31, lat, bcnt);
        chk("sll_dout", dout_w[1], 32'h8000_0000);
        chk("sll_lat", lat, 9);
        chk("sll_busy_cycles", bcnt, 9);

        do_op(2'b10, 32'hF000_0000, 5'd4, lat, bcnt);
        chk("sra_dout", dout_w[1], 32'hFF00_0000);
        chk("sra_lat", lat, 2);
        do_op(2'b01, 32'hF000_0000, 5'd4, lat, bcnt);
        chk("srl_dout", dout_w[1], 32'h0F00_0000);
        chk("srl_lat", lat, 2);

        do_op(2'b11, 32'h1234_5678, 5'd8, lat, bcnt);
        chk("ror_dout", dout_w[1], 32'h7812_3456);
        chk("ror_lat", lat, 3);

        do_op(2'b00, 32'hCAFE_BABE, 5'd0, lat, bcnt);
        chk("amt0_dout", dout_w[1], 32'hCAFE_BABE);
        chk("amt0_lat", lat, 1);
        chk("amt0_busy_cycles", bcnt, 1);

        // start pulses during SHIFT and DONE must be ignored
        @(negedge clk);
        start = 1'b1; op = 2'b00; din = 32'h0000_0F0F; amt = 5'd12;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; din = 32'hDEAD_BEEF; amt = 5'd1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !done_w[1]; k++) @(negedge clk);
        chk("hs_done_seen", {31'd0, done_w[1]}, 32'd1);
        start = 1'b1; op = 2'b11; din = 32'h5555_AAAA; amt = 5'd3;
        @(negedge clk);
        start = 1'b0;
        chk("hs_dout", dout_w[1], 32'h00F0_F000);
        wait_idle();
        $display("[TB] handshake: dout4=%h", dout_w[1]);

        // start held high: re-accepted after one IDLE cycle
        @(negedge clk);
        start = 1'b1; op = 2'b11; din = 32'h0000_00F1; amt = 5'd4;
        dmask = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 6 && done_w[1]) dmask |= (1 << (k - 1));
        end
        start = 1'b0;
        chk("held_done_pattern", dmask, 32'b010010);
        wait_idle();
        $display("[TB] held start: done mask=%b dout4=%h", dmask[5:0], dout_w[1]);

        // asynchronous reset in the middle of a shift
        @(negedge clk);
        start = 1'b1; op = 2'b00; din = 32'h0000_0003; amt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy_w[1]}, 32'd0);
        chk("arst_done", {31'd0, done_w[1]}, 32'd0);
        chk("arst_dout", dout_w[1], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_w[1]) dcnt++;
        end
        chk("arst_no_done", dcnt, 0);
        chk("arst_idle", {31'd0, busy_w[1]}, 32'd0);
        $display("[TB] mid-shift reset: dout4=%h done pulses=%0d", dout_w[1], dcnt);

        // sweep every op and amount; the per-cycle compare covers all three STEP values
        for (int o = 0; o < 4; o++) begin
            for (int a = 0; a < 32; a++) begin
                do_op(2'(o), $urandom, 5'(a), lat, bcnt);
                chk("sweep_lat4", lat, (a + 3) / 4 + 1);
            end
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised multi-cycle shifter for the MIPS datapath. It is the sequential successor to the fixed combinational left-shift-by-2 used in branch-target generation. It performs logical left, logical right, arithmetic right and rotate-right shifts by a variable amount, stepping at most STEP bit positions per clock. A start/busy/done handshake lets the ALU control stall on long shifts (sll/srl/sra/sllv/srlv/srav), so the datapath avoids a full-width single-cycle barrel shifter.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 4
- STEP, 4, maximum shift distance applied per cycle; power of two, 1 ≤ STEP ≤ WIDTH
- AW, $clog2(WIDTH), derived local parameter; width of amount field

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- amt  input  AW  shift distance, 0..WIDTH-1
- din  input  WIDTH  operand
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; dout valid and new
- dout  output  WIDTH  result register; holds last result until next completion

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with start=1 at edge E0 (acceptance):
  - capture din into work reg, op into op reg, amt into remaining counter (AW+1 bits);
  - if amt=0 go to DONE, else go to SHIFT.
- IDLE with start=0: no change.
- SHIFT, each edge:
  - s = min(remaining, STEP);
  - work shifted by s per the captured op; remaining -= s;
  - if the new remaining = 0, go to DONE and load dout with the shifted value in the same edge.
- For amt=0, dout is loaded with the captured din on entering DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Fill rules:
  - SLL shifts in zeros at the LSB.
  - SRL shifts in zeros at the MSB.
  - SRA shifts in the sign bit of the captured din, which is held constant across steps.
  - ROR moves bits shifted out of the LSB end into the MSB end.
- Final result equals the single-step equivalent: din<<amt, din>>amt, $signed(din)>>>amt, or rotate-right by amt, truncated to WIDTH.
- start while busy=1, including in the DONE cycle, is ignored. Operand inputs are not observed outside the acceptance edge.
- Back-to-back operations: earliest next acceptance is the edge after DONE, i.e. one IDLE cycle between operations.

## Timing
- Reset values: state IDLE, busy=0, done=0, dout=0; work reg and remaining counter 0.
- Reset asserted mid-operation aborts immediately (asynchronous). No done pulse is produced and dout is forced to 0.
- N = ceil(amt/STEP); N=0 for amt=0.
- busy rises in the cycle after E0 and falls in the cycle after DONE.
- done is high in the cycle following edge E0+N.
- dout changes only on the edge that raises done (or on reset).
- Latency from start sampled to done high: N+1 cycles, minimum 1 (amt=0) and maximum ceil((WIDTH-1)/STEP)+1.
- With STEP=WIDTH every nonzero amount completes in one SHIFT cycle.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- **Reset:** assert rst mid-SHIFT (WIDTH=32, STEP=4, SLL amt=20) → busy, done, dout drop to 0 asynchronously; after release, state is IDLE and no done pulse occurs.
- **SLL:** din=0x0000_0001, amt=31 → done in cycle 9 after acceptance (N=8), dout=0x8000_0000, busy high for exactly 9 cycles.
- **SRA vs SRL:** din=0xF000_0000, amt=4 → SRA gives dout=0xFF00_0000 and SRL gives 0x0F00_0000, each with done one cycle after the single SHIFT cycle (N=1).
- **ROR and zero amount:**
  - din=0x1234_5678, amt=8 → dout=0x7812_3456.
  - amt=0 → done in the first cycle after acceptance, dout=din, busy high 1 cycle.
- **Handshake:** pulse start again during SHIFT and during DONE with different din → ignored; the result matches the first operand. A start held high continuously is accepted again on the edge after DONE.
- **Randomised sweep:** all ops, amt 0..31 exhaustive, random din, STEP ∈ {1, 4, 32} → dout matches the reference expression and latency matches N+1 in every case.
